// File: rtl/vga_pkg.sv
// Shared constants, control codes and state encoding for the text console sequencer.
// Optional feature macro: VGA_CONSOLE_SCROLL_EN (adds the SCR_* scroll states).
package vga_pkg;

    localparam int unsigned CharsAcross    = 80;
    localparam int unsigned CharsDown      = 25;
    localparam int unsigned CharsAcrossLog = 7;
    localparam int unsigned RowW           = 5;
    localparam int unsigned AddrW          = RowW + CharsAcrossLog;
    localparam int unsigned DataW          = 8;

    localparam logic [CharsAcrossLog-1:0] LastCol = CharsAcrossLog'(CharsAcross - 1);
    localparam logic [RowW-1:0]           LastRow = RowW'(CharsDown - 1);

    localparam logic [DataW-1:0] ChSpace = 8'h20;
    localparam logic [DataW-1:0] ChBs    = 8'h08;
    localparam logic [DataW-1:0] ChLf    = 8'h0A;
    localparam logic [DataW-1:0] ChFf    = 8'h0C;
    localparam logic [DataW-1:0] ChCr    = 8'h0D;
    localparam logic [DataW-1:0] ChDel   = 8'h7F;

`ifdef VGA_CONSOLE_SCROLL_EN
    typedef enum logic [2:0] {
        INIT, IDLE, WRITE, SCR_RD, SCR_WAIT, SCR_WR, CLEAR
    } state_e;
`else
    typedef enum logic [2:0] {
        INIT, IDLE, WRITE, CLEAR
    } state_e;
`endif

    // Framebuffer address of a cell: row in the upper bits, column below.
    function automatic logic [AddrW-1:0] cell_addr(input logic [RowW-1:0] row,
                                                   input logic [CharsAcrossLog-1:0] col);
        return {row, col};
    endfunction

    // Bytes that place a glyph: everything from space upward except DEL.
    function automatic logic is_glyph(input logic [DataW-1:0] c);
        return (c >= ChSpace) && (c != ChDel);
    endfunction

endpackage

// File: rtl/vga_console_cursor.sv
// Cursor position registers with advance / newline / backspace handling.
// Newline on the bottom row raises scroll_req_c; with VGA_CONSOLE_SCROLL_EN the
// row stays at the bottom, otherwise it wraps to row 0.
module vga_console_cursor
    import vga_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_,
    input  logic                      advance,
    input  logic                      line_feed,
    input  logic                      carriage_ret,
    input  logic                      back_space,
    input  logic                      home,
    output logic [CharsAcrossLog-1:0] cursor_x,
    output logic [RowW-1:0]           cursor_y,
    output logic                      scroll_req_c
);

    logic at_last_col_c;
    logic newline_c;

    // Wrap detection: a newline happens on LF or when advancing past the last column.
    assign at_last_col_c = (cursor_x == LastCol);
    assign newline_c     = line_feed || (advance && at_last_col_c);
    assign scroll_req_c  = newline_c && (cursor_y == LastRow);

    // Cursor position update.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cursor_x <= '0;
            cursor_y <= '0;
        end else if (home) begin
            cursor_x <= '0;
            cursor_y <= '0;
        end else begin
            if (newline_c || carriage_ret) begin
                cursor_x <= '0;
            end else if (advance) begin
                cursor_x <= cursor_x + CharsAcrossLog'(1);
            end else if (back_space && (cursor_x != '0)) begin
                cursor_x <= cursor_x - CharsAcrossLog'(1);
            end
            if (newline_c) begin
                if (cursor_y != LastRow) begin
                    cursor_y <= cursor_y + RowW'(1);
                end
`ifndef VGA_CONSOLE_SCROLL_EN
                else begin
                    cursor_y <= '0;
                end
`endif
            end
        end
    end

endmodule

// File: rtl/vga_console_ctrl.sv
// Teletype sequencer driving framebuffer port A: glyph writes, screen clear, scroll.
// Optional feature macro: VGA_CONSOLE_SCROLL_EN (scroll on bottom-row newline;
// when undefined the cursor wraps to row 0 and that row is cleared instead).
module vga_console_ctrl
    import vga_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_,
    input  logic                      char_valid,
    input  logic [DataW-1:0]          char_data,
    output logic                      char_ready,
    output logic                      busy,
    output logic [CharsAcrossLog-1:0] cursor_x,
    output logic [RowW-1:0]           cursor_y,
    output logic [AddrW-1:0]          fb_addr,
    output logic [DataW-1:0]          fb_wdata,
    output logic                      fb_we,
    input  logic [DataW-1:0]          fb_rdata
);

`ifdef VGA_CONSOLE_SCROLL_EN
    localparam state_e NlState = SCR_RD;
`else
    localparam state_e NlState = CLEAR;
    logic unused_rdata;
    // Read data only feeds scroll copies.
    assign unused_rdata = ^fb_rdata;
`endif

    state_e state, next_state;

    logic [RowW-1:0]           scan_row, scan_row_d, step_row_c;
    logic [CharsAcrossLog-1:0] scan_col, scan_col_d, step_col_c;
    logic [AddrW-1:0]          fb_addr_d;
    logic [DataW-1:0]          fb_wdata_d;
    logic                      fb_we_d, char_ready_d, busy_d;
    logic                      accept_c, glyph_c, scan_end_c, row_end_c;
    logic                      adv_c, lf_c, cr_c, bs_c, ff_c, scroll_req_c;

    // Handshake decode and sweep-counter stepping (row-major).
    assign accept_c   = char_valid && (state == IDLE);
    assign glyph_c    = is_glyph(char_data);
    assign lf_c       = accept_c && (char_data == ChLf);
    assign cr_c       = accept_c && (char_data == ChCr);
    assign bs_c       = accept_c && (char_data == ChBs);
    assign ff_c       = accept_c && (char_data == ChFf);
    assign adv_c      = (state == WRITE);
    assign row_end_c  = (scan_col == LastCol);
    assign scan_end_c = row_end_c && (scan_row == LastRow);
    assign step_col_c = row_end_c ? '0 : scan_col + CharsAcrossLog'(1);
    assign step_row_c = row_end_c ? scan_row + RowW'(1) : scan_row;

    vga_console_cursor u_cursor (
        .clk          (clk),
        .rst_         (rst_),
        .advance      (adv_c),
        .line_feed    (lf_c),
        .carriage_ret (cr_c),
        .back_space   (bs_c),
        .home         (ff_c),
        .cursor_x     (cursor_x),
        .cursor_y     (cursor_y),
        .scroll_req_c (scroll_req_c)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state <= INIT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            INIT: begin
                if (fb_we && scan_end_c) next_state = IDLE;
            end
            IDLE: begin
                if (accept_c) begin
                    if (glyph_c)           next_state = WRITE;
                    else if (ff_c)         next_state = INIT;
                    else if (scroll_req_c) next_state = NlState;
                end
            end
            WRITE: begin
                next_state = scroll_req_c ? NlState : IDLE;
            end
`ifdef VGA_CONSOLE_SCROLL_EN
            SCR_RD:   next_state = SCR_WAIT;
            SCR_WAIT: next_state = SCR_WR;
            SCR_WR:   next_state = scan_end_c ? CLEAR : SCR_RD;
`endif
            CLEAR: begin
                if (row_end_c) next_state = IDLE;
            end
            default: next_state = INIT;
        endcase
    end

    // Next values of the registered port-A outputs, handshake flags and sweep counter.
    always_comb begin
        fb_addr_d    = fb_addr;
        fb_wdata_d   = fb_wdata;
        fb_we_d      = 1'b0;
        scan_row_d   = scan_row;
        scan_col_d   = scan_col;
        char_ready_d = (next_state == IDLE);
        busy_d       = !((next_state == IDLE) || (next_state == WRITE));
        if (scroll_req_c) begin
`ifdef VGA_CONSOLE_SCROLL_EN
            // First scroll source cell is (1,0); reads carry no write enable.
            scan_row_d = RowW'(1);
            scan_col_d = '0;
            fb_addr_d  = cell_addr(RowW'(1), '0);
`else
            // Wrap to the top: blank row 0.
            scan_row_d = '0;
            scan_col_d = '0;
            fb_addr_d  = cell_addr('0, '0);
            fb_wdata_d = ChSpace;
            fb_we_d    = 1'b1;
`endif
        end else begin
            case (state)
                INIT: begin
                    if (!fb_we) begin
                        // Only seen right after reset: issue the first cell.
                        fb_we_d    = 1'b1;
                        fb_addr_d  = cell_addr(scan_row, scan_col);
                        fb_wdata_d = ChSpace;
                    end else if (!scan_end_c) begin
                        scan_row_d = step_row_c;
                        scan_col_d = step_col_c;
                        fb_we_d    = 1'b1;
                        fb_addr_d  = cell_addr(step_row_c, step_col_c);
                        fb_wdata_d = ChSpace;
                    end
                end
                IDLE: begin
                    if (accept_c && glyph_c) begin
                        fb_we_d    = 1'b1;
                        fb_addr_d  = cell_addr(cursor_y, cursor_x);
                        fb_wdata_d = char_data;
                    end else if (ff_c) begin
                        scan_row_d = '0;
                        scan_col_d = '0;
                        fb_we_d    = 1'b1;
                        fb_addr_d  = cell_addr('0, '0);
                        fb_wdata_d = ChSpace;
                    end
                end
`ifdef VGA_CONSOLE_SCROLL_EN
                SCR_WAIT: begin
                    // Read data is valid now; write it one row up.
                    fb_we_d    = 1'b1;
                    fb_addr_d  = cell_addr(scan_row - RowW'(1), scan_col);
                    fb_wdata_d = fb_rdata;
                end
                SCR_WR: begin
                    if (scan_end_c) begin
                        scan_row_d = LastRow;
                        scan_col_d = '0;
                        fb_we_d    = 1'b1;
                        fb_addr_d  = cell_addr(LastRow, '0);
                        fb_wdata_d = ChSpace;
                    end else begin
                        scan_row_d = step_row_c;
                        scan_col_d = step_col_c;
                        fb_addr_d  = cell_addr(step_row_c, step_col_c);
                    end
                end
`endif
                CLEAR: begin
                    if (!row_end_c) begin
                        scan_col_d = step_col_c;
                        fb_we_d    = 1'b1;
                        fb_addr_d  = cell_addr(scan_row, step_col_c);
                        fb_wdata_d = ChSpace;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output and sweep-counter registers.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            fb_addr    <= '0;
            fb_wdata   <= '0;
            fb_we      <= 1'b0;
            char_ready <= 1'b0;
            busy       <= 1'b1;
            scan_row   <= '0;
            scan_col   <= '0;
        end else begin
            fb_addr    <= fb_addr_d;
            fb_wdata   <= fb_wdata_d;
            fb_we      <= fb_we_d;
            char_ready <= char_ready_d;
            busy       <= busy_d;
            scan_row   <= scan_row_d;
            scan_col   <= scan_col_d;
        end
    end

endmodule

// File: tb/tb_vga_console_ctrl.sv
// Bench for vga_console_ctrl: screen/cursor model plus a port-A RAM model.
// Honours VGA_CONSOLE_SCROLL_EN the same way as the design.
`timescale 1ns/1ps
module tb_vga_console_ctrl;

    localparam int Cols = 80;
    localparam int Rows = 25;
`ifdef VGA_CONSOLE_SCROLL_EN
    localparam bit ScrollEn = 1'b1;
`else
    localparam bit ScrollEn = 1'b0;
`endif
    localparam int NlCycles = ScrollEn ? 3 * (Rows - 1) * Cols + Cols : Cols;
    localparam int NlWrites = ScrollEn ? (Rows - 1) * Cols + Cols : Cols;
    localparam int Bound    = 8000;

    logic        clk = 1'b0;
    logic        rst_;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready;
    logic        busy;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic [11:0] fb_addr;
    logic [7:0]  fb_wdata;
    logic        fb_we;
    logic [7:0]  fb_rdata;

    logic [7:0]  mem [0:4095];
    logic        scramble;
    int          wr_cnt  = 0;
    int          bad_col = 0;
    logic [19:0] wr_log [$];

    logic [7:0]  scr [0:Rows-1][0:Cols-1];
    int          mx, my;
    int          n_vec = 0;
    int          n_err = 0;

    vga_console_ctrl dut (
        .clk        (clk),
        .rst_       (rst_),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .busy       (busy),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y),
        .fb_addr    (fb_addr),
        .fb_wdata   (fb_wdata),
        .fb_we      (fb_we),
        .fb_rdata   (fb_rdata)
    );

    always #10 clk = ~clk;

    // Synchronous RAM, port A: registered read, write on fb_we.
    always @(posedge clk) begin
        if (scramble) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 8'($urandom);
        end else if (fb_we) begin
            mem[fb_addr] <= fb_wdata;
        end
        fb_rdata <= mem[fb_addr];
    end

    // Write monitor.
    always @(posedge clk) begin
        if (rst_ && fb_we) begin
            wr_cnt <= wr_cnt + 1;
            if (fb_addr[6:0] >= 7'd80) bad_col <= bad_col + 1;
            wr_log.push_back({fb_addr, fb_wdata});
        end
    end

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic int screen_diffs();
        int n = 0;
        for (int r = 0; r < Rows; r++)
            for (int c = 0; c < Cols; c++)
                if (mem[r * 128 + c] !== scr[r][c]) n++;
        return n;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < Rows; r++)
            for (int c = 0; c < Cols; c++) scr[r][c] = 8'h20;
        mx = 0;
        my = 0;
    endtask

    task automatic model_newline(output int cyc, output int wr);
        cyc = 0;
        wr  = 0;
        if (my < Rows - 1) begin
            my++;
        end else begin
            if (ScrollEn) begin
                for (int r = 0; r < Rows - 1; r++)
                    for (int c = 0; c < Cols; c++) scr[r][c] = scr[r + 1][c];
                for (int c = 0; c < Cols; c++) scr[Rows - 1][c] = 8'h20;
            end else begin
                my = 0;
                for (int c = 0; c < Cols; c++) scr[0][c] = 8'h20;
            end
            cyc = NlCycles;
            wr  = NlWrites;
        end
    endtask

    // Effect of one character: latency to ready, busy cycles, RAM writes.
    task automatic model_char(input logic [7:0] c, output int lat, output int bsy, output int wr);
        int nc, nw;
        lat = 1;
        bsy = 0;
        wr  = 0;
        if (c >= 8'h20 && c != 8'h7F) begin
            scr[my][mx] = c;
            lat = 2;
            wr  = 1;
            if (mx < Cols - 1) begin
                mx++;
            end else begin
                mx = 0;
                model_newline(nc, nw);
                lat += nc;
                bsy = nc;
                wr += nw;
            end
        end else if (c == 8'h0A) begin
            mx = 0;
            model_newline(nc, nw);
            lat += nc;
            bsy = nc;
            wr  = nw;
        end else if (c == 8'h0D) begin
            mx = 0;
        end else if (c == 8'h08) begin
            if (mx > 0) mx--;
        end else if (c == 8'h0C) begin
            model_clear();
            lat = 1 + Rows * Cols;
            bsy = Rows * Cols;
            wr  = Rows * Cols;
        end
    endtask

    // Offer one byte, wait for acceptance and for ready to return; called at a negedge.
    task automatic send_char(input logic [7:0] c, output int lat, output int bsy);
        int t = 0;
        char_valid = 1'b1;
        char_data  = c;
        while (!char_ready && t < Bound) begin
            @(negedge clk);
            t++;
        end
        lat = 1;
        bsy = 0;
        @(posedge clk);
        @(negedge clk);
        char_valid = 1'b0;
        while (!char_ready && lat < Bound) begin
            if (busy) bsy++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_char(input logic [7:0] c, input string tag);
        int el, eb, ew, lat, bsy, w0;
        w0 = wr_cnt;
        model_char(c, el, eb, ew);
        send_char(c, lat, bsy);
        check_eq({tag, "_lat"}, lat, el);
        check_eq({tag, "_busy"}, bsy, eb);
        check_eq({tag, "_writes"}, wr_cnt - w0, ew);
        check_eq({tag, "_cx"}, 32'(cursor_x), mx);
        check_eq({tag, "_cy"}, 32'(cursor_y), my);
        check_eq({tag, "_screen"}, screen_diffs(), 0);
    endtask

    // Release reset and verify the power-on clear sweep.
    task automatic reset_and_init(input string tag);
        int i0, t, n, bad;
        logic [19:0] ent, want;
        i0 = wr_log.size();
        rst_ = 1'b1;
        t = 0;
        while (!char_ready && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check_eq({tag, "_ready"}, 32'(char_ready), 1);
        check_eq({tag, "_busy_done"}, 32'(busy), 0);
        n = wr_log.size() - i0;
        check_eq({tag, "_writes"}, n, Rows * Cols);
        bad = 0;
        for (int k = 0; k < n && k < Rows * Cols; k++) begin
            ent  = wr_log[i0 + k];
            want = {5'(k / Cols), 7'(k % Cols), 8'h20};
            if (ent !== want) bad++;
        end
        check_eq({tag, "_order"}, bad, 0);
        model_clear();
        check_eq({tag, "_cx"}, 32'(cursor_x), 0);
        check_eq({tag, "_cy"}, 32'(cursor_y), 0);
        check_eq({tag, "_screen"}, screen_diffs(), 0);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_we"}, 32'(fb_we), 0);
        check_eq({tag, "_addr"}, 32'(fb_addr), 0);
        check_eq({tag, "_wdata"}, 32'(fb_wdata), 0);
        check_eq({tag, "_ready"}, 32'(char_ready), 0);
        check_eq({tag, "_busy"}, 32'(busy), 1);
        check_eq({tag, "_cx"}, 32'(cursor_x), 0);
        check_eq({tag, "_cy"}, 32'(cursor_y), 0);
    endtask

    function automatic logic [7:0] rand_glyph();
        logic [7:0] c;
        c = 8'($urandom_range(8'h20, 8'hFF));
        if (c == 8'h7F) c = 8'h7E;
        return c;
    endfunction

    initial begin
        logic [19:0] ent;
        logic [7:0]  c, last;
        logic [7:0]  junk [0:7];
        int i0, r;

        junk[0] = 8'h00; junk[1] = 8'h01; junk[2] = 8'h07; junk[3] = 8'h09;
        junk[4] = 8'h0B; junk[5] = 8'h1B; junk[6] = 8'h1F; junk[7] = 8'h7F;
        char_valid = 1'b0;
        char_data  = 8'h00;
        scramble   = 1'b1;
        rst_       = 1'b1;
        #1 rst_ = 1'b0;
        #1 check_reset_values("rst");
        repeat (3) @(negedge clk);
        scramble = 1'b0;
        @(negedge clk);
        reset_and_init("init");

        // 'A' then 'B' at the home position.
        i0 = wr_log.size();
        do_char(8'h41, "chA");
        ent = wr_log[i0];
        check_eq("chA_log", 32'(ent), 32'({12'h000, 8'h41}));
        i0 = wr_log.size();
        do_char(8'h42, "chB");
        ent = wr_log[i0];
        check_eq("chB_log", 32'(ent), 32'({12'h001, 8'h42}));

        // A full row of glyphs starting at (3,0).
        do_char(8'h0D, "cr0");
        for (int k = 0; k < 3; k++) do_char(8'h0A, "lf_to3");
        last = 8'h00;
        for (int k = 0; k < Cols; k++) begin
            last = rand_glyph();
            do_char(last, "row3");
        end
        ent = wr_log[wr_log.size() - 1];
        check_eq("row3_last", 32'(ent), 32'({5'd3, 7'd79, last}));
        check_eq("row3_cx", 32'(cursor_x), 0);
        check_eq("row3_cy", 32'(cursor_y), 4);

        // Clear, fill row 1 with '1', then newline from the bottom row.
        do_char(8'h0C, "ff");
        do_char(8'h0A, "lf_to1");
        for (int k = 0; k < Cols; k++) do_char(8'h31, "row1");
        while (my < Rows - 1) do_char(8'h0A, "lf_down");
        do_char(8'h0A, "lf_bottom");

        // Backspace at column 0, carriage return from column 40.
        do_char(8'h08, "bs_col0");
        for (int k = 0; k < 40; k++) do_char(rand_glyph(), "fill40");
        check_eq("fill40_cx", 32'(cursor_x), 40);
        do_char(8'h0D, "cr40");
        do_char(8'h08, "bs_after_cr");

        // Randomized mix of glyphs and control codes.
        for (int k = 0; k < 40; k++) begin
            r = int'($urandom_range(0, 99));
            if (r < 10)      c = 8'h0A;
            else if (r < 14) c = 8'h0D;
            else if (r < 19) c = 8'h08;
            else if (r < 21) c = 8'h0C;
            else if (r < 26) c = junk[$urandom_range(0, 7)];
            else             c = rand_glyph();
            do_char(c, "rnd");
        end

        // Reset while a bottom-row newline sequence is running.
        while (my < Rows - 1) do_char(8'h0A, "lf_down2");
        char_valid = 1'b1;
        char_data  = 8'h0A;
        @(posedge clk);
        @(negedge clk);
        char_valid = 1'b0;
        repeat (40) @(negedge clk);
        check_eq("mid_busy", 32'(busy), 1);
        #2 rst_ = 1'b0;
        #1 check_reset_values("midrst");
        @(negedge clk);
        reset_and_init("reinit");
        do_char(8'h5A, "post_reset");

        check_eq("col_range", bad_col, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
